rtc_time_keeper: RTL and testbench

//  Parametrised hh:mm:ss time-of-day core; successor to the fixed 16-bit-divider clock counter.
//  - Adds run/stop, a validated preset load, per-field increment for key-driven setting, and 12/24 h display.
//  - Sits between the system clock and segment_show.
//  - Provides binary time, display hour, second/day strobes.

---
 rtl/rtc_pkg.sv | 28 ++
 rtl/mod_n_counter.sv | 43 ++++
 rtl/rtc_time_keeper.sv | 128 ++++++++++++
 tb/tb_rtc_time_keeper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the hh:mm:ss time-of-day core.
package rtc_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    INC_NONE = 2'b00,
    INC_SEC  = 2'b01,
    INC_MIN  = 2'b10,
    INC_HOUR = 2'b11
  } inc_sel_e;

  // 24 h hour to 12 h clock-face hour: midnight and noon both show 12.
  function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h > 5'd12) begin
      r = h - 5'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N field counter with synchronous load, setting increment and carry-chained enable.
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         carry_out
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  assign at_max = (value_q == W'(N - 1));

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc || en) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  // A setting increment wraps silently; only a counting enable propagates a carry.
  assign carry_out = en && at_max && !load && !inc;
  assign value     = value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/rtc_time_keeper.sv
// Time-of-day core: prescaler, pending-tick arbitration, three chained field counters, 12 h decode.
module rtc_time_keeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  output logic       load_err,
  input  logic [1:0] inc_sel,
  input  logic       inc_pulse,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [4:0] disp_hour,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             load_err_q, load_err_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             day_pulse_q, day_pulse_d;

  logic tick, load_fire, load_ok, load_acc, inc_act, apply_tick;
  logic sec_carry, min_carry, hour_carry;

  // Preset handshake: a preset transfers on any cycle where load_valid && load_ready;
  // ready is always high, so the transfer is decided by load_valid alone and the
  // outcome (accepted or rejected via load_err) is visible on the following cycle.
  assign load_ready = 1'b1;

  always_comb begin
    tick       = run && (cnt_q == CNT_LAST);
    load_fire  = load_valid && load_ready;
    load_ok    = (load_hour <= 5'(HOUR_MAX)) && (load_min <= 6'(MIN_MAX))
                 && (load_sec <= 6'(SEC_MAX));
    load_acc   = load_fire && load_ok;
    inc_act    = !load_fire && inc_pulse && (inc_sel != INC_NONE);
    apply_tick = !load_fire && !inc_act && (tick || pend_q);

    cnt_d = cnt_q;
    if (load_acc || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    // Any cycle that owns the time registers (inc or rejected load) parks a coincident
    // tick so the time-of-day does not lose a second.
    pend_d = 1'b0;
    if (!load_acc && (load_fire || inc_act)) begin
      pend_d = pend_q || tick;
    end

    load_err_d  = load_fire && !load_ok;
    sec_pulse_d = apply_tick;
    day_pulse_d = hour_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      load_err_q  <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      load_err_q  <= load_err_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  mod_n_counter #(.N(SEC_MAX + 1), .W(6)) u_sec (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_acc),
    .load_val  (load_sec),
    .inc       (inc_act && (inc_sel == INC_SEC)),
    .en        (apply_tick),
    .value     (second),
    .carry_out (sec_carry)
  );

  mod_n_counter #(.N(MIN_MAX + 1), .W(6)) u_min (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_acc),
    .load_val  (load_min),
    .inc       (inc_act && (inc_sel == INC_MIN)),
    .en        (sec_carry),
    .value     (minute),
    .carry_out (min_carry)
  );

  mod_n_counter #(.N(HOUR_MAX + 1), .W(5)) u_hour (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_acc),
    .load_val  (load_hour),
    .inc       (inc_act && (inc_sel == INC_HOUR)),
    .en        (min_carry),
    .value     (hour),
    .carry_out (hour_carry)
  );

  assign disp_hour = mode_12h ? hour_to_12h(hour) : hour;
  assign pm        = (hour >= 5'd12);
  assign load_err  = load_err_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Directed plus randomized bench for rtc_time_keeper against a seconds-of-day reference model.
module tb_rtc_time_keeper;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       mode_12h;
  logic       load_valid;
  logic       load_ready;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       load_err;
  logic [1:0] inc_sel;
  logic       inc_pulse;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [4:0] disp_hour;
  logic       pm;
  logic       sec_pulse;
  logic       day_pulse;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: time as seconds since midnight, prescaler phase, parked tick.
  int m_tod;
  int m_cnt;
  bit m_pend;
  bit m_secp;
  bit m_dayp;
  bit m_err;

  // clock / reset block
  always #5 clk = ~clk;

  rtc_time_keeper #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mode_12h   (mode_12h),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .load_err   (load_err),
    .inc_sel    (inc_sel),
    .inc_pulse  (inc_pulse),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .disp_hour  (disp_hour),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .day_pulse  (day_pulse)
  );

  function automatic int face_hour(input int h);
    if (h == 0) return 12;
    if (h <= 12) return h;
    return h - 12;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_cnt = 0; m_pend = 0; m_secp = 0; m_dayp = 0; m_err = 0;
  endtask

  task automatic model_step();
    int h, mi, s;
    bit tick;
    tick = run && (m_cnt == TD - 1);
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    m_secp = 0; m_dayp = 0; m_err = 0;
    if (run) m_cnt = (m_cnt + 1) % TD;
    if (load_valid) begin
      if (load_hour < 24 && load_min < 60 && load_sec < 60) begin
        m_tod  = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
        m_cnt  = 0;
        m_pend = 0;
      end else begin
        m_err  = 1;
        m_pend = m_pend || tick;
      end
    end else if (inc_pulse && inc_sel != 2'b00) begin
      case (inc_sel)
        2'b01:   s  = (s + 1) % 60;
        2'b10:   mi = (mi + 1) % 60;
        default: h  = (h + 1) % 24;
      endcase
      m_tod  = h * 3600 + mi * 60 + s;
      m_pend = m_pend || tick;
    end else if (tick || m_pend) begin
      m_dayp = (m_tod == 86399);
      m_tod  = (m_tod + 1) % 86400;
      m_secp = 1;
      m_pend = 0;
    end
  endtask

  task automatic check_model();
    int h;
    h = m_tod / 3600;
    chk("hour", 32'(hour), h);
    chk("minute", 32'(minute), (m_tod / 60) % 60);
    chk("second", 32'(second), m_tod % 60);
    chk("sec_pulse", 32'(sec_pulse), 32'(m_secp));
    chk("day_pulse", 32'(day_pulse), 32'(m_dayp));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("load_ready", 32'(load_ready), 1);
    chk("pm", 32'(pm), (h >= 12) ? 1 : 0);
    chk("disp_hour", 32'(disp_hour), mode_12h ? face_hour(h) : h);
  endtask

  // driver: one clock, model update at the edge, outputs sampled 1 ns later
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_load(input int h, input int mi, input int s);
    load_valid = 1'b1;
    load_hour  = 5'(h);
    load_min   = 6'(mi);
    load_sec   = 6'(s);
    cyc();
    load_valid = 1'b0;
  endtask

  initial begin : main
    int pulses, days, saved_tod;
    int hs[4]  = '{0, 12, 13, 23};
    int eds[4] = '{12, 12, 1, 11};
    int epm[4] = '{0, 1, 1, 1};

    rst_n = 1'b0; run = 1'b0; mode_12h = 1'b0; load_valid = 1'b0;
    load_hour = '0; load_min = '0; load_sec = '0; inc_sel = 2'b00; inc_pulse = 1'b0;
    model_reset();

    // reset state
    #3;
    check_model();
    #9;
    rst_n = 1'b1;
    mode_12h = 1'b1;
    #1;
    chk("disp_hour_12h_midnight", 32'(disp_hour), 12);
    mode_12h = 1'b0;

    // free run from reset
    run = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      pulses += int'(sec_pulse);
    end
    chk("second_after_8", 32'(second), 2);
    chk("sec_pulses_in_8", pulses, 2);

    // rollover through midnight
    do_load(23, 59, 58);
    days = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      days += int'(day_pulse);
    end
    chk("day_pulses", days, 1);
    chk("midnight_tod", 32'(hour) * 3600 + 32'(minute) * 60 + 32'(second), 0);

    // rejected presets
    do_load(5, 6, 7);
    saved_tod = m_tod;
    run = 1'b0;
    do_load(24, 0, 0);
    chk("err_hour24", 32'(load_err), 1);
    do_load(0, 60, 0);
    chk("err_min60", 32'(load_err), 1);
    cyc();
    chk("err_clears", 32'(load_err), 0);
    chk("tod_after_rej", 32'(hour) * 3600 + 32'(minute) * 60 + 32'(second), saved_tod);

    // freeze at prescaler phase 2
    run = 1'b1;
    for (int i = 0; i < 8 && m_cnt != 2; i++) cyc();
    chk("reached_cnt2", m_cnt, 2);
    run = 1'b0;
    saved_tod = m_tod;
    repeat (10) cyc();
    chk("frozen_second", 32'(second), saved_tod % 60);
    run = 1'b1;
    repeat (3) cyc();

    // field increment without carry, then inc colliding with a tick
    do_load(10, 59, 59);
    inc_sel = 2'b10; inc_pulse = 1'b1;
    cyc();
    inc_pulse = 1'b0;
    chk("inc_min_hour", 32'(hour), 10);
    chk("inc_min_min", 32'(minute), 0);
    chk("inc_min_sec", 32'(second), 59);
    for (int i = 0; i < 8 && m_cnt != TD - 1; i++) cyc();
    inc_sel = 2'b01; inc_pulse = 1'b1;
    cyc();
    inc_pulse = 1'b0;
    chk("inc_tick_no_pulse", 32'(sec_pulse), 0);
    chk("inc_tick_sec", 32'(second), 0);
    cyc();
    chk("pending_pulse", 32'(sec_pulse), 1);
    chk("pending_sec", 32'(second), 1);
    chk("pending_min", 32'(minute), 0);

    // 12 h decode
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_load(hs[i], 30, 0);
      mode_12h = 1'b1;
      #1;
      chk("disp12", 32'(disp_hour), eds[i]);
      chk("pm12", 32'(pm), epm[i]);
      mode_12h = 1'b0;
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      run        = ($urandom_range(0, 9) != 0);
      mode_12h   = 1'($urandom_range(0, 1));
      load_valid = ($urandom_range(0, 24) == 0);
      load_hour  = 5'($urandom_range(0, 31));
      load_min   = 6'($urandom_range(0, 63));
      load_sec   = 6'($urandom_range(0, 63));
      inc_pulse  = ($urandom_range(0, 5) == 0);
      inc_sel    = 2'($urandom_range(0, 3));
      cyc();
    end
    load_valid = 1'b0; inc_pulse = 1'b0; run = 1'b1;

    // asynchronous reset mid-operation
    do_load(5, 6, 7);
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_hour", 32'(hour), 0);
    chk("arst_minute", 32'(minute), 0);
    chk("arst_second", 32'(second), 0);
    chk("arst_sec_pulse", 32'(sec_pulse), 0);
    chk("arst_day_pulse", 32'(day_pulse), 0);
    #10;
    rst_n = 1'b1;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
